// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Stall/flush sequencer for the 5-stage pipeline. It produces the hold (pause)
// and bubble (nop) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers, plus the PC enable. It also keeps stall/flush performance
// counters and a watchdog on data-memory waits.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   ihit, dhit           icache / dcache completion this cycle
//   dmem_req             MEM-stage instruction accesses dmem
//   ex_memread, ex_rd    load in ID/EX and its destination register
//   id_rs, id_rt         IF/ID source registers
//   id_jump              IF/ID holds a jump
//   br_taken             EX/MEM holds a resolved taken branch
//   halt_wb              MEM/WB holds HALT
//   pc_en                PC may load its next value
//   *_pause, *_nop       per-register hold / bubble (nop wins over pause)
//   halted, mem_timeout  sticky status flags
//   stall_count          cycles with pc_en low while not halted (saturating)
//   flush_count          taken-branch flushes (saturating)
//
// state | meaning
// RUN   | normal issue
// DWAIT | waiting for dcache to complete a MEM-stage access
// HALT  | core halted, absorbing until reset
module pipeline_hazard_controller #(
    parameter int CNT_W     = 32,
    parameter int DWAIT_MAX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_jump,
    input  logic             br_taken,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_pause,
    output logic             idex_pause,
    output logic             exmem_pause,
    output logic             memwb_pause,
    output logic             ifid_nop,
    output logic             idex_nop,
    output logic             exmem_nop,
    output logic             memwb_nop,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int DW_W = $clog2(DWAIT_MAX + 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW_W-1:0] dw_cnt;
    logic            mem_wait;
    logic            load_use;
    logic            flush_hit;

    assign mem_wait = dmem_req & ~dhit;
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));
    assign halted   = (state == S_HALT);

    // State register plus counters and watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RUN;
            dw_cnt      <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_RUN && state_nxt == S_DWAIT) begin
                dw_cnt <= '0;
            end else if (state == S_DWAIT && dw_cnt != DW_W'(DWAIT_MAX)) begin
                dw_cnt <= dw_cnt + DW_W'(1);
            end

            // Flag at the edge where dw_cnt becomes DWAIT_MAX
            if (state == S_DWAIT && dw_cnt >= DW_W'(DWAIT_MAX - 1)) begin
                mem_timeout <= 1'b1;
            end

            if (!pc_en && state != S_HALT && stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end

            if (flush_hit && flush_count != '1) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    // Next-state logic; a DWAIT ignores halt_wb until the access completes
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (halt_wb)       state_nxt = S_HALT;
                else if (mem_wait) state_nxt = S_DWAIT;
            end
            S_DWAIT: begin
                if (dhit) state_nxt = S_RUN;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RUN;
        endcase
    end

    // Output logic, priority ordered: first matching condition wins
    always_comb begin
        pc_en       = 1'b1;
        ifid_pause  = 1'b0;
        idex_pause  = 1'b0;
        exmem_pause = 1'b0;
        memwb_pause = 1'b0;
        ifid_nop    = 1'b0;
        idex_nop    = 1'b0;
        exmem_nop   = 1'b0;
        memwb_nop   = 1'b0;
        flush_hit   = 1'b0;
        if (rst) begin
            pc_en     = 1'b0;
            ifid_nop  = 1'b1;
            idex_nop  = 1'b1;
            exmem_nop = 1'b1;
            memwb_nop = 1'b1;
        end else if (state == S_HALT || mem_wait) begin
            pc_en       = 1'b0;
            ifid_pause  = 1'b1;
            idex_pause  = 1'b1;
            exmem_pause = 1'b1;
            memwb_pause = 1'b1;
        end else if (br_taken) begin
            ifid_nop  = 1'b1;
            idex_nop  = 1'b1;
            exmem_nop = 1'b1;
            flush_hit = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_pause = 1'b1;
            idex_nop   = 1'b1;
        end else if (!ihit) begin
            // Fetch bubble only; downstream stages keep advancing
            pc_en    = 1'b0;
            ifid_nop = 1'b1;
        end else if (id_jump) begin
            ifid_nop = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (CNT_W=4, DWAIT_MAX=4).
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ihit, dhit, dmem_req, ex_memread, id_jump, br_taken, halt_wb;
    logic [4:0]       ex_rd, id_rs, id_rt;
    logic             pc_en, ifid_pause, idex_pause, exmem_pause, memwb_pause;
    logic             ifid_nop, idex_nop, exmem_nop, memwb_nop;
    logic             halted, mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic [8:0]       ctrl;

    int n_assert = 0;
    int n_fail   = 0;

    // ctrl = {pc_en, pauses ifid..memwb, nops ifid..memwb}
    localparam logic [8:0] C_RST   = 9'b0_0000_1111;
    localparam logic [8:0] C_RUN   = 9'b1_0000_0000;
    localparam logic [8:0] C_STALL = 9'b0_1111_0000;
    localparam logic [8:0] C_FLUSH = 9'b1_0000_1110;
    localparam logic [8:0] C_LDUSE = 9'b0_1000_0100;
    localparam logic [8:0] C_NOI   = 9'b0_0000_1000;
    localparam logic [8:0] C_JUMP  = 9'b1_0000_1000;

    always #5 clk = ~clk;

    assign ctrl = {pc_en, ifid_pause, idex_pause, exmem_pause, memwb_pause,
                   ifid_nop, idex_nop, exmem_nop, memwb_nop};

    pipeline_hazard_controller #(.CNT_W(CNT_W), .DWAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_jump(id_jump), .br_taken(br_taken), .halt_wb(halt_wb),
        .pc_en(pc_en), .ifid_pause(ifid_pause), .idex_pause(idex_pause),
        .exmem_pause(exmem_pause), .memwb_pause(memwb_pause),
        .ifid_nop(ifid_nop), .idex_nop(idex_nop), .exmem_nop(exmem_nop),
        .memwb_nop(memwb_nop), .halted(halted), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and checks happen 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0; ex_memread = 1'b0;
        id_jump = 1'b0; br_taken = 1'b0; halt_wb = 1'b0;
        ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'(C_RST));
        chk("rst_halted", 32'(halted), 0);
        chk("rst_timeout", 32'(mem_timeout), 0);
        chk("rst_stall", 32'(stall_count), 0);
        chk("rst_flush", 32'(flush_count), 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        do_reset();

        chk("idle_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();

        // Load-use through rs, then rt
        ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; #1;
        chk("lu_rs_ctrl", 32'(ctrl), 32'(C_LDUSE));
        tick();
        chk("lu_rs_stall", 32'(stall_count), 1);
        ex_rd = 5'd9; id_rs = 5'd3; id_rt = 5'd9; #1;
        chk("lu_rt_ctrl", 32'(ctrl), 32'(C_LDUSE));
        tick();
        chk("lu_rt_stall", 32'(stall_count), 2);

        // r0 is never a hazard
        ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; #1;
        chk("lu_r0_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        chk("lu_r0_stall", 32'(stall_count), 2);

        idle(); ihit = 1'b0; #1;
        chk("imiss_ctrl", 32'(ctrl), 32'(C_NOI));
        tick();
        chk("imiss_stall", 32'(stall_count), 3);

        idle(); id_jump = 1'b1; #1;
        chk("jump_ctrl", 32'(ctrl), 32'(C_JUMP));
        tick();

        // Load-use outranks an icache miss
        idle(); ihit = 1'b0; ex_memread = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; #1;
        chk("lu_vs_imiss", 32'(ctrl), 32'(C_LDUSE));
        tick();
        chk("lu_vs_imiss_stall", 32'(stall_count), 4);

        // Taken branch ignores ihit and the load-use above
        br_taken = 1'b1; #1;
        chk("br_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        chk("br_flush", 32'(flush_count), 1);
        chk("br_stall", 32'(stall_count), 4);

        // Five cycles of dmem wait then completion; DWAIT_MAX=4 trips on 4th DWAIT edge
        idle(); dmem_req = 1'b1; #1;
        for (int i = 1; i <= 5; i++) begin
            chk("dw_ctrl", 32'(ctrl), 32'(C_STALL));
            tick();
            chk("dw_timeout", 32'(mem_timeout), (i >= 5) ? 1 : 0);
        end
        chk("dw_stall", 32'(stall_count), 9);
        dhit = 1'b1; br_taken = 1'b1; #1;
        chk("dw_exit_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        chk("dw_exit_stall", 32'(stall_count), 9);
        chk("dw_exit_flush", 32'(flush_count), 2);

        // Reset clears sticky timeout and counters
        idle();
        do_reset();

        // Six waiting cycles, then reset mid-DWAIT
        dmem_req = 1'b1; #1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("t6_timeout", 32'(mem_timeout), (i >= 5) ? 1 : 0);
        end
        chk("t6_stall", 32'(stall_count), 6);
        do_reset();

        // After reset the FSM is in RUN, so halt_wb is honoured
        idle(); halt_wb = 1'b1; #1;
        chk("halt_req_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        halt_wb = 1'b0; #1;
        chk("halt_flag", 32'(halted), 1);
        chk("halt_ctrl", 32'(ctrl), 32'(C_STALL));
        tick(); tick(); tick();
        chk("halt_frozen_stall", 32'(stall_count), 0);
        chk("halt_sticky", 32'(halted), 1);
        do_reset();

        // Halt with a taken branch: flush this cycle, halted next
        halt_wb = 1'b1; br_taken = 1'b1; #1;
        chk("t5_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        halt_wb = 1'b0; #1;
        chk("t5_halted", 32'(halted), 1);
        chk("t5_ctrl_next", 32'(ctrl), 32'(C_STALL));
        tick(); tick();
        chk("t5_flush", 32'(flush_count), 1);
        chk("t5_stall", 32'(stall_count), 0);
        do_reset();

        // Halt coinciding with a dmem wait: stall counted once, then frozen
        idle(); halt_wb = 1'b1; dmem_req = 1'b1; #1;
        chk("hw_dw_ctrl", 32'(ctrl), 32'(C_STALL));
        tick();
        idle(); dhit = 1'b1; #1;
        chk("hw_dw_halted", 32'(halted), 1);
        chk("hw_dw_ctrl2", 32'(ctrl), 32'(C_STALL));
        tick(); tick();
        chk("hw_dw_stall", 32'(stall_count), 1);
        idle();
        do_reset();

        // Counter saturation at 4'hF
        ihit = 1'b0; #1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i >= 14) chk("stall_sat", 32'(stall_count), (i > 15) ? 15 : i);
        end
        idle(); br_taken = 1'b1; #1;
        for (int i = 1; i <= 16; i++) tick();
        chk("flush_sat", 32'(flush_count), 15);
        chk("flush_sat_stall", 32'(stall_count), 15);
        idle();
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
